// File: rtl/mm_pass_controller.sv
// Sequences one 8x8 matrix through the 4-lane MAC ALU: row load, two 32-cycle passes, result write-back.
// Optional ALU handshake checking is compiled in with `define MMC_ERRCHK_EN.
module mm_pass_controller #(
  parameter int ROWS     = 8,
  parameter int PASS_CYC = 32,
  parameter int MU_W     = 18,
  parameter int RES_AW   = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [63:0]             in_data,
  output logic                    in_ready,
  output logic                    buf_we,
  output logic [$clog2(ROWS)-1:0] buf_waddr,
  output logic [63:0]             buf_wdata,
  output logic                    buf_pass,
  output logic                    alu_en,
  input  logic [MU_W-1:0]         mu1,
  input  logic [MU_W-1:0]         mu2,
  input  logic [MU_W-1:0]         mu3,
  input  logic [MU_W-1:0]         mu4,
  input  logic                    alu_web,
  input  logic                    alu_done,
  output logic                    res_we,
  output logic [RES_AW-1:0]       res_addr,
  output logic [MU_W-1:0]         res_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(PASS_CYC);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_CYC = CW'(PASS_CYC - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    GAP   = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t          state;
  logic [CW-1:0]   cyc;
  logic            gap_rerun;
  logic            capture;
  logic            wr_active;
  logic [1:0]      wr_lane;
  logic [1:0]      next_lane;
  logic [MU_W-1:0] hold [4];

  // The row counter doubles as the buffer write address, so buf_we can be the raw handshake.
  assign buf_we    = in_valid & in_ready;
  assign buf_wdata = in_data;
  assign capture   = (state == RUN) && (cyc[2:0] == 3'd7);
  assign next_lane = wr_lane + 2'd1;

  // Main sequencer: load, two passes separated by a one-cycle alu_en gap, drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      buf_waddr <= '0;
      cyc       <= '0;
      buf_pass  <= 1'b0;
      gap_rerun <= 1'b0;
      in_ready  <= 1'b0;
      alu_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            buf_waddr <= '0;
            cyc       <= '0;
            buf_pass  <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (buf_waddr == LAST_ROW) begin
              state     <= RUN;
              buf_waddr <= '0;
              in_ready  <= 1'b0;
              alu_en    <= 1'b1;
              cyc       <= '0;
            end else begin
              buf_waddr <= buf_waddr + RW'(1);
            end
          end
        end
        RUN: begin
          if (cyc == LAST_CYC) begin
            // Pass flips on entry to GAP so buf_pass only moves while alu_en is low.
            state     <= GAP;
            alu_en    <= 1'b0;
            cyc       <= '0;
            gap_rerun <= ~buf_pass;
            buf_pass  <= 1'b1;
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        GAP: begin
          if (gap_rerun) begin
            state  <= RUN;
            alu_en <= 1'b1;
            cyc    <= '0;
          end else begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!wr_active) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          alu_en   <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // Write engine: capture the lane sums at a column boundary, then emit four result words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_active <= 1'b0;
      wr_lane   <= 2'd0;
      res_we    <= 1'b0;
      res_addr  <= '0;
      res_data  <= '0;
      hold      <= '{default: '0};
    end else if (capture) begin
      hold[0]   <= mu1;
      hold[1]   <= mu2;
      hold[2]   <= mu3;
      hold[3]   <= mu4;
      wr_active <= 1'b1;
      wr_lane   <= 2'd0;
      res_we    <= 1'b1;
      res_addr  <= {buf_pass, cyc[CW-1:3], 2'd0};
      res_data  <= mu1;
    end else if (wr_active) begin
      if (wr_lane == 2'd3) begin
        wr_active <= 1'b0;
        res_we    <= 1'b0;
      end else begin
        wr_lane  <= next_lane;
        res_addr <= {res_addr[RES_AW-1:2], next_lane};
        res_data <= hold[next_lane];
      end
    end
  end

`ifdef MMC_ERRCHK_EN
  logic exp_web;
  logic exp_done;

  // Protocol monitor: alu_web must follow each capture by one cycle, alu_done must follow cyc 31.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err      <= 1'b0;
      exp_web  <= 1'b0;
      exp_done <= 1'b0;
    end else begin
      exp_web  <= capture;
      exp_done <= (state == RUN) && (cyc == LAST_CYC);
      if ((state == IDLE) && start) begin
        err <= 1'b0;
      end else if (((state == RUN) || (state == GAP)) && (alu_web != exp_web)) begin
        err <= 1'b1;
      end else if ((state != IDLE) && (alu_done != exp_done)) begin
        err <= 1'b1;
      end
    end
  end
`else
  logic unused_alu;
  assign unused_alu = alu_web ^ alu_done;
  assign err        = 1'b0;
`endif

endmodule
